// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dma_pkg
//  Description : Shared types and constants for the DMA copy engine:
//                FSM state encoding, length width, word stride and the
//                default staging FIFO depth. The ERR state exists only
//                when DMA_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

    localparam int          c_LEN_W          = 16;
    localparam logic [31:0] c_WORD_STRIDE    = 32'd4;
    localparam int          c_FIFO_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_REQ = 3'd1,
        ST_RD_GAP = 3'd2,
        ST_WR_REQ = 3'd3,
        ST_WR_GAP = 3'd4,
        ST_FIN    = 3'd5
`ifdef DMA_TIMEOUT_EN
        ,
        ST_ERR    = 3'd6
`endif
    } dma_state_t;

    // Number of words to move in the next read/write chunk
    function automatic logic [c_LEN_W-1:0] chunk_words(
        input logic [c_LEN_W-1:0] remaining,
        input int unsigned        depth
    );
        if (32'(remaining) > depth) begin
            return c_LEN_W'(depth);
        end
        return remaining;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dma_fifo
//  Description : Synchronous single-clock FIFO used to stage one chunk of
//                words between the read and write phases. Push on full and
//                pop on empty are ignored. i_flush empties it in one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_fifo
    import dma_pkg::*;
#(
    parameter int DEPTH = c_FIFO_DEPTH_DEF,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; contents need no reset because r_count gates validity
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap freely
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : dma_copy_engine
//  Description : Wishbone DMA master copying cfg_len 32-bit words from
//                cfg_src to cfg_dst, one single-beat transaction per word,
//                staged through dma_fifo in chunks of up to FIFO_DEPTH.
//                Every ack is followed by one idle cycle so the downstream
//                SDRAM arbiter can hand the bus to a waiting CPU request.
//                Optional feature macro: DMA_TIMEOUT_EN (per-transaction
//                ack timeout with sticky err flag).
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_copy_engine
    import dma_pkg::*;
#(
    parameter int FIFO_DEPTH     = c_FIFO_DEPTH_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        cfg_src,
    input  logic [31:0]        cfg_dst,
    input  logic [c_LEN_W-1:0] cfg_len,
    input  logic               cfg_start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               dma_stb_o,
    output logic               dma_cyc_o,
    output logic               dma_we_o,
    output logic [3:0]         dma_sel_o,
    output logic [31:0]        dma_adr_o,
    output logic [31:0]        dma_dat_o,
    input  logic               dma_ack_i,
    input  logic [31:0]        dma_dat_i
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

    dma_state_t         r_state;
    logic [31:0]        r_src_ptr;
    logic [31:0]        r_dst_ptr;
    logic [c_LEN_W-1:0] r_remaining;
    logic [c_LEN_W-1:0] r_rd_left;
    logic               r_busy;
    logic               r_done;
    logic               r_stb;
    logic               r_we;
    logic [3:0]         r_sel;
    logic [31:0]        r_adr;
    logic [31:0]        r_dat;

    logic [31:0]        w_cfg_src_al;
    logic [31:0]        w_cfg_dst_al;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic [31:0]        w_fifo_head;
    logic [c_CNT_W-1:0] w_fifo_count;
    logic               w_unused;

    // Byte-address low bits carry no meaning for word transfers
    assign w_cfg_src_al = {cfg_src[31:2], 2'b00};
    assign w_cfg_dst_al = {cfg_dst[31:2], 2'b00};

    // Ack is only returned while a request is up, so state alone qualifies it
    assign w_push = (r_state == ST_RD_REQ) && dma_ack_i;
    assign w_pop  = (r_state == ST_WR_REQ) && dma_ack_i;

    assign busy      = r_busy;
    assign done      = r_done;
    assign dma_stb_o = r_stb;
    assign dma_cyc_o = r_stb;
    assign dma_we_o  = r_we;
    assign dma_sel_o = r_sel;
    assign dma_adr_o = r_adr;
    assign dma_dat_o = r_dat;

    assign w_unused = ^{cfg_src[1:0], cfg_dst[1:0], w_fifo_full, w_fifo_count,
                        (TIMEOUT_CYCLES == 0)};

`ifdef DMA_TIMEOUT_EN
    localparam int                 c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TMO_W-1:0] r_wait;
    logic               r_err;
    logic               w_timeout;

    assign w_timeout = !dma_ack_i && (r_wait == c_TMO_LAST);
    assign w_flush   = (r_state == ST_ERR);
    assign err       = r_err;

    // Stalled-cycle counter; every non-request state clears it so each
    // request starts counting from zero
    always_ff @(posedge clk) begin
        if (rst || ((r_state != ST_RD_REQ) && (r_state != ST_WR_REQ))) begin
            r_wait <= '0;
        end else if (!dma_ack_i) begin
            r_wait <= r_wait + c_TMO_W'(1);
        end
    end
`else
    assign w_flush = 1'b0;
    assign err     = 1'b0;
`endif

    dma_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (dma_dat_i),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

    // Transfer sequencer: bus request outputs are registered and set up on
    // the edge that enters a request state, so they are stable while waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_remaining <= '0;
            r_rd_left   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= 4'h0;
            r_adr       <= '0;
            r_dat       <= '0;
`ifdef DMA_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        r_src_ptr   <= w_cfg_src_al;
                        r_dst_ptr   <= w_cfg_dst_al;
                        r_remaining <= cfg_len;
`ifdef DMA_TIMEOUT_EN
                        r_err       <= 1'b0;
`endif
                        if (cfg_len == '0) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_RD_REQ;
                            r_busy    <= 1'b1;
                            r_rd_left <= chunk_words(cfg_len, FIFO_DEPTH);
                            r_stb     <= 1'b1;
                            r_we      <= 1'b0;
                            r_sel     <= 4'hF;
                            r_adr     <= w_cfg_src_al;
                        end
                    end
                end

                ST_RD_REQ: begin
                    if (dma_ack_i) begin
                        r_src_ptr <= r_src_ptr + c_WORD_STRIDE;
                        r_rd_left <= r_rd_left - c_LEN_W'(1);
                        r_stb     <= 1'b0;
                        r_sel     <= 4'h0;
                        r_state   <= ST_RD_GAP;
                    end
`ifdef DMA_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_stb   <= 1'b0;
                        r_sel   <= 4'h0;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_ERR;
                    end
`endif
                end

                ST_RD_GAP: begin
                    r_stb <= 1'b1;
                    r_sel <= 4'hF;
                    if (r_rd_left != '0) begin
                        r_state <= ST_RD_REQ;
                        r_we    <= 1'b0;
                        r_adr   <= r_src_ptr;
                    end else begin
                        r_state <= ST_WR_REQ;
                        r_we    <= 1'b1;
                        r_adr   <= r_dst_ptr;
                        r_dat   <= w_fifo_head;
                    end
                end

                ST_WR_REQ: begin
                    if (dma_ack_i) begin
                        r_dst_ptr   <= r_dst_ptr + c_WORD_STRIDE;
                        r_remaining <= r_remaining - c_LEN_W'(1);
                        r_stb       <= 1'b0;
                        r_we        <= 1'b0;
                        r_sel       <= 4'h0;
                        r_state     <= ST_WR_GAP;
                    end
`ifdef DMA_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_sel   <= 4'h0;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_ERR;
                    end
`endif
                end

                ST_WR_GAP: begin
                    if (!w_fifo_empty) begin
                        r_state <= ST_WR_REQ;
                        r_stb   <= 1'b1;
                        r_we    <= 1'b1;
                        r_sel   <= 4'hF;
                        r_adr   <= r_dst_ptr;
                        r_dat   <= w_fifo_head;
                    end else if (r_remaining != '0) begin
                        r_state   <= ST_RD_REQ;
                        r_rd_left <= chunk_words(r_remaining, FIFO_DEPTH);
                        r_stb     <= 1'b1;
                        r_we      <= 1'b0;
                        r_sel     <= 4'hF;
                        r_adr     <= r_src_ptr;
                    end else begin
                        r_state <= ST_FIN;
                        r_done  <= 1'b1;
                    end
                end

                ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

`ifdef DMA_TIMEOUT_EN
                ST_ERR: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
`endif

                default: begin
                    r_busy  <= 1'b0;
                    r_stb   <= 1'b0;
                    r_we    <= 1'b0;
                    r_sel   <= 4'h0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_copy_engine
//  Description : Self-checking bench for dma_copy_engine. A Wishbone slave
//                model with per-transaction latency answers the DUT; a
//                chunked copy model predicts the bus transaction sequence,
//                completion timing and destination contents.
//                Timeout scenario is built only with DMA_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_copy_engine;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
    } op_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_src = '0;
    logic [31:0] cfg_dst = '0;
    logic [15:0] cfg_len = '0;
    logic        cfg_start = 1'b0;
    logic        busy, done, err;
    logic        dma_stb_o, dma_cyc_o, dma_we_o;
    logic [3:0]  dma_sel_o;
    logic [31:0] dma_adr_o, dma_dat_o;
    logic        dma_ack_i;
    logic [31:0] dma_dat_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave model state (owned by the responder process except the knobs)
    int          cyc_cnt   = 0;
    int          wait_cnt  = 0;
    int          cur_lat   = 0;
    int          n_acks    = 0;
    int          lat_fixed = 0;
    bit          withhold  = 1'b0;
    int          withhold_at = 0;
    logic [31:0] dmem [4096];

    always #5 clk = ~clk;

    dma_copy_engine #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_src   (cfg_src),
        .cfg_dst   (cfg_dst),
        .cfg_len   (cfg_len),
        .cfg_start (cfg_start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dma_stb_o (dma_stb_o),
        .dma_cyc_o (dma_cyc_o),
        .dma_we_o  (dma_we_o),
        .dma_sel_o (dma_sel_o),
        .dma_adr_o (dma_adr_o),
        .dma_dat_o (dma_dat_o),
        .dma_ack_i (dma_ack_i),
        .dma_dat_i (dma_dat_i)
    );

    // Source memory contents: a fixed function of the word address
    function automatic logic [31:0] pattern(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Combinational ack after the selected number of wait cycles
    always_comb begin
        dma_ack_i = 1'b0;
        if (dma_stb_o && (wait_cnt >= ((lat_fixed >= 0) ? lat_fixed : cur_lat))
            && !(withhold && (n_acks == withhold_at)))
            dma_ack_i = 1'b1;
    end

    assign dma_dat_i = pattern(dma_adr_o);

    // Slave responder: wait counting, new random latency per ack, write capture
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (dma_stb_o && dma_ack_i) begin
            wait_cnt <= 0;
            cur_lat  <= int'($urandom_range(0, 3));
            n_acks   <= n_acks + 1;
            if (dma_we_o)
                dmem[dma_adr_o[13:2]] <= dma_dat_o;
        end else if (dma_stb_o) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    // Start one transfer, watch the bus until done, compare against the model
    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst,
                            input int len, input int poke, input bit exp_tmo,
                            input string tag);
        op_t         exp_q[$];
        op_t         obs_q[$];
        op_t         op;
        logic [31:0] chunk[$];
        logic [31:0] s, d, a;
        int          rem, c, done_k, stb_cyc, busy_bad, n;
        bit          prev_ack;

        // Reference: copy proceeds in chunks of min(remaining, DEPTH)
        s   = src & ~32'h3;
        d   = dst & ~32'h3;
        rem = len;
        while (rem > 0) begin
            c = (rem < DEPTH) ? rem : DEPTH;
            chunk.delete();
            for (int i = 0; i < c; i++) begin
                op.we = 1'b0; op.adr = s; op.dat = pattern(s);
                exp_q.push_back(op);
                chunk.push_back(pattern(s));
                s += 32'd4;
            end
            for (int i = 0; i < c; i++) begin
                op.we = 1'b1; op.adr = d; op.dat = chunk[i];
                exp_q.push_back(op);
                d += 32'd4;
            end
            rem -= c;
        end
        if (exp_tmo)
            while (exp_q.size() > 1) void'(exp_q.pop_back());

        @(negedge clk);
        cfg_src     = src;
        cfg_dst     = dst;
        cfg_len     = 16'(len);
        cfg_start   = 1'b1;
        withhold_at = n_acks + 1;

        done_k = 0; stb_cyc = 0; busy_bad = 0; prev_ack = 1'b0;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            cfg_start = (k == poke);
            if (k == poke) begin
                cfg_src = $urandom;
                cfg_dst = $urandom;
                cfg_len = 16'($urandom_range(1, 30));
            end
            if (k == 1) begin
                check({tag, " busy_at_start"}, busy, (len != 0));
                check({tag, " err_cleared"}, err, 0);
            end
            if (prev_ack)
                check({tag, " gap_after_ack"}, dma_stb_o, 0);
            if (dma_stb_o)
                stb_cyc++;
            if (dma_stb_o && dma_ack_i) begin
                op.we  = dma_we_o;
                op.adr = dma_adr_o;
                op.dat = dma_dat_o;
                obs_q.push_back(op);
                check({tag, " sel"}, dma_sel_o, 4'hF);
                check({tag, " cyc"}, dma_cyc_o, 1);
            end
            prev_ack = dma_stb_o && dma_ack_i;
            if ((len != 0) != busy)
                busy_bad++;
            if (done) begin
                done_k = k;
                break;
            end
        end
        cfg_start = 1'b0;

        check({tag, " done_seen"}, (done_k != 0), 1);
        check({tag, " busy_window"}, busy_bad, 0);
        check({tag, " err_at_done"}, err, exp_tmo);
        if (exp_tmo) begin
            check({tag, " stb_cycles"}, stb_cyc, 1 + TMO);
            check({tag, " done_cycle"}, done_k, 3 + TMO);
        end else if (lat_fixed == 0) begin
            check({tag, " done_cycle"}, done_k, (len == 0) ? 1 : 4 * len + 1);
        end
        if (len == 0)
            check({tag, " no_stb"}, stb_cyc, 0);

        check({tag, " n_ops"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, " op_we"}, obs_q[i].we, exp_q[i].we);
            check({tag, " op_adr"}, obs_q[i].adr, exp_q[i].adr);
            if (exp_q[i].we)
                check({tag, " op_dat"}, obs_q[i].dat, exp_q[i].dat);
        end

        @(negedge clk);
        check({tag, " done_one_cycle"}, done, 0);
        check({tag, " busy_after"}, busy, 0);
        check({tag, " stb_after"}, dma_stb_o, 0);

        if (!exp_tmo) begin
            for (int i = 0; i < len; i++) begin
                a = (dst & ~32'h3) + 32'(4 * i);
                check({tag, " dst_mem"}, dmem[a[13:2]], pattern((src & ~32'h3) + 32'(4 * i)));
            end
        end
    endtask

    initial begin
        int          dones;
        bit          found;
        logic [31:0] rs, rd;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst stb", dma_stb_o, 0);
        check("rst cyc", dma_cyc_o, 0);
        check("rst we", dma_we_o, 0);
        check("rst sel", dma_sel_o, 0);
        check("rst adr", dma_adr_o, 0);
        check("rst dat", dma_dat_o, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        rst = 1'b0;

        lat_fixed = 0;
        run_xfer(32'h0000_0100, 32'h0000_0200, 3, 0, 1'b0, "len3");
        run_xfer(32'h0000_0100, 32'h0000_0200, 0, 0, 1'b0, "len0");
        run_xfer(32'h0000_1000, 32'h0000_2000, 9, 0, 1'b0, "len9");
        run_xfer(32'h0000_1400, 32'h0000_2400, 6, 5, 1'b0, "midstart");

        lat_fixed = -1;
        run_xfer(32'hFFFF_FFFB, 32'h0000_0301, 5, 0, 1'b0, "wrap");
        for (int t = 0; t < 6; t++) begin
            rs = $urandom & 32'h0FFF_FFFF;
            rd = $urandom | 32'h8000_0000;
            run_xfer(rs, rd, int'($urandom_range(1, 20)),
                     int'($urandom_range(0, 12)), 1'b0, "rand");
        end

`ifdef DMA_TIMEOUT_EN
        lat_fixed = 0;
        withhold  = 1'b1;
        run_xfer(32'h0000_3000, 32'h0000_3400, 4, 0, 1'b1, "timeout");
        withhold  = 1'b0;
        run_xfer(32'h0000_3800, 32'h0000_3C00, 2, 0, 1'b0, "after_tmo");
`endif

        // Reset while a write request is stalled
        lat_fixed = 3;
        @(negedge clk);
        cfg_src = 32'h0000_5000; cfg_dst = 32'h0000_6000; cfg_len = 16'd5;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (dma_stb_o && dma_we_o && !dma_ack_i) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("midrst reached_write", found, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst stb", dma_stb_o, 0);
        check("midrst cyc", dma_cyc_o, 0);
        rst = 1'b0;
        dones = (done === 1'b1) ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("midrst no_done", dones, 0);
        check("midrst busy", busy, 0);
        lat_fixed = 0;
        run_xfer(32'h0000_7000, 32'h0000_7800, 1, 0, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/dma_copy_engine.md
# dma_copy_engine

Wishbone DMA master that copies a block of 32-bit words from a source SDRAM address to a destination SDRAM address. It sits directly upstream of the CPU/DMA SDRAM arbiter and drives the arbiter's DMA request port. Words are staged through a small internal FIFO, one Wishbone transaction per word. The block is configured and started by a pulse from the register block.

## Interface
- `FIFO_DEPTH`, 4: words staged per read/write chunk; power of two, ≥2.
- `TIMEOUT_CYCLES`, 255: maximum wait cycles per transaction for `dma_ack_i`; used only with `DMA_TIMEOUT_EN`.
- `clk` in 1: single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_src` in 32: source byte address; bits [1:0] ignored and treated as 0.
- `cfg_dst` in 32: destination byte address; bits [1:0] ignored and treated as 0.
- `cfg_len` in 16: transfer length in words.
- `cfg_start` in 1: one-cycle start pulse.
- `busy` out 1: high from the accepted start until `done`.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky timeout flag.
- `dma_stb_o`, `dma_cyc_o`, `dma_we_o` out 1 each: Wishbone master strobe, cycle and write-enable.
- `dma_sel_o` out 4: byte selects; always 4'hF while a request is active.
- `dma_adr_o` out 32: Wishbone address.
- `dma_dat_o` out 32: Wishbone write data.
- `dma_ack_i` in 1: Wishbone acknowledge, returned combinationally through the arbiter.
- `dma_dat_i` in 32: read data from SDRAM, valid in the same cycle as `dma_ack_i`.

## Operation
- States:
  - IDLE: waiting for a start.
  - RD_REQ: read request on the bus.
  - RD_GAP: one idle cycle after a read ack.
  - WR_REQ: write request on the bus.
  - WR_GAP: one idle cycle after a write ack.
  - FIN: signals completion.
  - ERR: timeout exit, only with `DMA_TIMEOUT_EN`.
- IDLE:
  - On `cfg_start`, latch src, dst and len, and clear `err`.
  - If len == 0, go to FIN with no bus traffic; otherwise go to RD_REQ.
- `cfg_start` outside IDLE is ignored.
- Read phase:
  - Chunk size = min(remaining, FIFO_DEPTH).
  - RD_REQ drives stb=cyc=1, we=0, adr=src_ptr.
  - On ack, push `dma_dat_i` into the FIFO and add 4 to src_ptr, then go to RD_GAP.
  - From RD_GAP, return to RD_REQ if the chunk is not yet read, else go to WR_REQ.
- Write phase:
  - WR_REQ drives stb=cyc=we=1, adr=dst_ptr, dat=FIFO head.
  - On ack, pop the FIFO, add 4 to dst_ptr and decrement remaining, then go to WR_GAP.
  - From WR_GAP:
    - FIFO not empty: back to WR_REQ.
    - FIFO empty and remaining > 0: back to RD_REQ.
    - FIFO empty and remaining == 0: go to FIN.
- FIN: pulse `done`, drop `busy`, return to IDLE.
- Gap cycles hold stb/cyc low for one cycle after every ack. This releases the arbiter's busy flag and lets a pending CPU request win.
- Request signals stay stable while waiting for ack; `sel` stays 4'hF.
- Address pointers wrap modulo 2^32.
- The FIFO never overflows: the chunk size never exceeds FIFO_DEPTH, and a chunk is fully drained before the next read phase.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, pointers 0.
- `cfg_start` at cycle N puts the first `dma_stb_o` high at N+1.
- A zero-wait ack (stb and ack in the same cycle) gives 2 cycles per word per direction. With ack latency L, each word costs L+2 cycles per direction.
- len == 0: `done` pulses at N+1, `busy` stays 0.
- `done` asserts the cycle after the WR_GAP that follows the final write ack.
- `busy` is 1 from N+1 through the FIN cycle inclusive.
- `rst` mid-transfer: stb/cyc drop in the cycle after `rst` is sampled, the FIFO flushes, and no `done` pulse is produced.

## Configuration
- Macro: `DMA_TIMEOUT_EN`.
- Defined:
  - A counter restarts on each entry to RD_REQ or WR_REQ.
  - If it reaches TIMEOUT_CYCLES without an ack, deassert stb/cyc next cycle and enter ERR.
  - ERR sets `err` and pulses `done` for one cycle, then returns to IDLE.
  - `err` stays set until the next accepted start.
- Undefined: the block waits for ack indefinitely, `err` is tied to 0 and the ERR state is not built.

## Structure
- Shared package `dma_pkg`:
  - State enum.
  - Length width (16).
  - Word stride constant (4).
  - Default `FIFO_DEPTH`.
- Sub-module `dma_fifo`: synchronous FIFO, parameterised depth and width 32, with push/pop/empty/full and count.
- The FSM, pointers and counters live in the top module.

## Test plan
- src=0x100, dst=0x200, len=3, memory 0x100..0x108 = A,B,C, zero-wait ack -> reads 0x100/0x104/0x108, then writes A/B/C to 0x200/0x204/0x208; `done` at cycle 13 after start.
- len=0 -> no stb ever asserted; `done` pulse at N+1; `busy` stays 0.
- len=9, FIFO_DEPTH=4 -> bus order is R4, W4, R4, W4, R1, W1; destination matches source.
- `cfg_start` pulsed mid-transfer with different cfg values -> ignored; the original transfer completes unchanged.
- `DMA_TIMEOUT_EN`, TIMEOUT_CYCLES=8, ack withheld on the 2nd read -> stb drops after 8 waiting cycles; `err`=1 and one `done` pulse; the next start clears `err`.
- `rst` asserted during a write wait -> stb/cyc are 0 the next cycle, no `done`; a new len=1 transfer then completes correctly.
